// File: rtl/sample_readback_unpacker_pkg.sv
// sample_readback_unpacker_pkg: shared widths, lane geometry and FSM encoding
package sample_readback_unpacker_pkg;
    localparam int DATA_WIDTH      = 128;
    localparam int SAMPLE_WIDTH    = 32;
    localparam int ADX_WIDTH       = 27;
    localparam int ADX_STEP        = 8;
    localparam int MAX_OUTSTANDING = 4;
    localparam int CNT_WIDTH       = 16;
    localparam int LANES           = DATA_WIDTH / SAMPLE_WIDTH;
    localparam int IDX_WIDTH       = $clog2(LANES);
    localparam int OUT_WIDTH       = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(LANES - 1);
    localparam logic [OUT_WIDTH-1:0] OUT_MAX  = OUT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [ADX_WIDTH-1:0] ADX_INC  = ADX_WIDTH'(ADX_STEP);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
endpackage

// File: rtl/sample_readback_unpacker_if.sv
// sample_readback_unpacker_if: memory read/return bus plus the sample stream
interface sample_readback_unpacker_if;
    import sample_readback_unpacker_pkg::*;
    logic                    read_req;
    logic [ADX_WIDTH-1:0]    rd_adx;
    logic                    read_allowed;
    logic                    has_return_data;
    logic [DATA_WIDTH-1:0]   return_data;
    logic [ADX_WIDTH-1:0]    return_adx;
    logic                    get_return_data;
    logic [SAMPLE_WIDTH-1:0] sample_out;
    logic                    sample_valid;
    logic                    sample_ready;
    modport master (
        output read_req, rd_adx, get_return_data, sample_out, sample_valid,
        input  read_allowed, has_return_data, return_data, return_adx, sample_ready
    );
    modport slave (
        input  read_req, rd_adx, get_return_data, sample_out, sample_valid,
        output read_allowed, has_return_data, return_data, return_adx, sample_ready
    );
endinterface

// File: rtl/sample_lane_serializer.sv
// sample_lane_serializer: holds one DRAM word and emits its lanes LSB-first on valid/ready
module sample_lane_serializer
    import sample_readback_unpacker_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic                    ready,
    output logic [SAMPLE_WIDTH-1:0] sample,
    output logic                    valid,
    output logic                    can_load
);
    logic [LANES-1:0][SAMPLE_WIDTH-1:0] word_q;
    logic [IDX_WIDTH-1:0]               idx;
    logic                               hs;

    // a new word may enter when empty or while the last lane is leaving
    always_comb begin
        hs       = valid & ready;
        can_load = ~valid | (hs & (idx == LAST_IDX));
        sample   = word_q[idx];
    end

    // buffer reload takes priority; otherwise step lanes on each handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            idx    <= '0;
            valid  <= 1'b0;
        end else if (load) begin
            word_q <= data;
            idx    <= '0;
            valid  <= 1'b1;
        end else if (hs) begin
            idx    <= idx + 1'b1;
            valid  <= idx != LAST_IDX;
        end
    end
endmodule

// File: rtl/sample_readback_unpacker.sv
// sample_readback_unpacker: issues bounded DRAM reads and unpacks returns into 32-bit samples
module sample_readback_unpacker
    import sample_readback_unpacker_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADX_WIDTH-1:0] start_adx,
    input  logic [CNT_WIDTH-1:0] num_words,
    output logic                 busy,
    output logic                 done,
    output logic                 adx_error,
    sample_readback_unpacker_if.master bus
);
    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] words_q, issued, received;
    logic [ADX_WIDTH-1:0] next_adx, exp_adx;
    logic [OUT_WIDTH-1:0] outstanding;
    logic                 issue, pop, can_load;

    sample_lane_serializer u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (pop),
        .data     (bus.return_data),
        .ready    (bus.sample_ready),
        .sample   (bus.sample_out),
        .valid    (bus.sample_valid),
        .can_load (can_load)
    );

    // issue/pop decisions and next state; counting happens on the decision so in-flight never overshoots
    always_comb begin
        issue   = (state == RUN) && (issued < words_q) && (outstanding < OUT_MAX) && bus.read_allowed;
        pop     = (state == RUN) && bus.has_return_data && can_load;
        bus.get_return_data = pop;
        busy    = state == RUN;
        state_n = state == IDLE ? (start ? (num_words == '0 ? FINISH : RUN) : IDLE) :
                  state == RUN  ? ((received == words_q && !bus.sample_valid) ? FINISH : RUN) :
                  IDLE;
    end

    // state, registered read command, address tracking and in-flight accounting
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            done         <= 1'b0;
            adx_error    <= 1'b0;
            bus.read_req <= 1'b0;
            bus.rd_adx   <= '0;
            words_q      <= '0;
            issued       <= '0;
            received     <= '0;
            next_adx     <= '0;
            exp_adx      <= '0;
            outstanding  <= '0;
        end else begin
            state        <= state_n;
            done         <= state == FINISH;
            bus.read_req <= issue;
            outstanding  <= outstanding + OUT_WIDTH'(issue) - OUT_WIDTH'(pop);
            if (state == IDLE && start) begin
                words_q   <= num_words;
                next_adx  <= start_adx;
                exp_adx   <= start_adx;
                issued    <= '0;
                received  <= '0;
                adx_error <= 1'b0;
            end else begin
                if (issue) begin
                    bus.rd_adx <= next_adx;
                    next_adx   <= next_adx + ADX_INC;
                    issued     <= issued + 1'b1;
                end
                if (pop) begin
                    exp_adx  <= exp_adx + ADX_INC;
                    received <= received + 1'b1;
                    if (bus.return_adx != exp_adx)
                        adx_error <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/sample_readback_unpacker.md
Name: sample_readback_unpacker

Overview:
- Readback engine between the DDR memory interface and the logic-capture readback path.
- Issues sequential 128-bit read requests for a captured region, bounding the number of reads in flight.
- Pops returned 128-bit words and serialises each into four 32-bit sample packets on a valid/ready stream, which the hub drains to the UART.
- Mirror of the write-side packer: restores samples in the same order they were packed.

Parameters:
- DATA_WIDTH, 128, width of DRAM return word.
- SAMPLE_WIDTH, 32, width of one sample packet; DATA_WIDTH/SAMPLE_WIDTH = 4 lanes.
- ADX_WIDTH, 27, DRAM address width.
- ADX_STEP, 8, address increment per 128-bit word.
- MAX_OUTSTANDING, 4, maximum issued-but-not-popped reads.
- CNT_WIDTH, 16, width of the word-count input and internal counters.

Ports:
- clk  in  1  system clock (soc clock domain)
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begin readback; ignored while busy
- start_adx  in  27  first DRAM word address, sampled on start
- num_words  in  16  number of 128-bit words to read, sampled on start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the final sample is accepted downstream
- adx_error  out  1  sticky; return_adx mismatched the expected address; cleared on start
- read_req  out  1  read command pulse to memory interface
- rd_adx  out  27  address accompanying read_req
- read_allowed  in  1  memory interface can accept a read this cycle
- has_return_data  in  1  return FIFO non-empty (first-word fall-through)
- return_data  in  128  head of return FIFO
- return_adx  in  27  address of head word
- get_return_data  out  1  pop return FIFO this cycle
- sample_out  out  32  current sample packet
- sample_valid  out  1  sample_out valid
- sample_ready  in  1  downstream accepts sample this cycle

Behaviour:
- Reset values: busy, done, adx_error, read_req, get_return_data, sample_valid all 0; rd_adx 0; sample_out 0. All counters and buffer state cleared. Reset mid-transfer aborts immediately; no done pulse.
- FSM states:
  - IDLE: on start, latch start_adx and num_words, clear adx_error, go to RUN. If num_words==0, go to FINISH instead.
  - RUN: issue reads and unpack; go to FINISH when received==num_words, buffer empty and no lane pending.
  - FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Issue logic (RUN only):
  - read_req=1 (registered, one cycle) when issued<num_words, outstanding<MAX_OUTSTANDING and read_allowed.
  - rd_adx = start_adx + issued*ADX_STEP, modulo 2^27; wrap past 0x7FFFFFF is silent.
  - issued increments per read_req.
- Outstanding counter:
  - +1 on read_req, -1 on get_return_data; both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING.
- Pop logic: get_return_data is combinational = RUN & has_return_data & (buffer empty | last-lane handshake this cycle).
  - On that edge: return_data is latched into the 128-bit buffer, lane index set to 0, received increments.
  - If return_adx differs from expected (start_adx + received*ADX_STEP), adx_error is set; data is still used.
- Unpack: sample_out = buffer lane[idx]; lane 0 = bits[31:0] first, lane 3 = bits[127:96] last.
  - sample_valid is high while the buffer holds unconsumed lanes.
  - idx advances on sample_valid&sample_ready.
  - A pop on the last-lane handshake gives back-to-back words at 1 sample/cycle.
- sample_out holds stable while sample_valid & ~sample_ready.
- has_return_data outside RUN is never popped.
- Latency: start to first read_req = 2 cycles (start→RUN, then registered req). Pop to first sample_valid = 1 cycle.

Decomposition:
- Shared package: lane count, ADX_STEP, FSM state encoding (IDLE/RUN/FINISH).
- One natural sub-module, sample_lane_serializer: 128-bit buffer, lane index, valid/ready, reload-on-last handshake.
- Issue/outstanding/FSM logic stays in the top.

Test Plan:
- start_adx=0x100, num_words=2, read_allowed=1, memory returns in order, sample_ready=1 -> read_req at adx 0x100 and 0x108; 8 samples emitted in lane order 0..3 per word; done pulses once; adx_error=0.
- num_words=10, memory never returns data -> exactly 4 read_req pulses, then read_req held low; outstanding=4.
- sample_ready toggled 0/1 randomly, 3 words -> no sample lost or duplicated; sample_out stable while stalled; 12 samples total.
- start_adx=0x7FFFFF8, num_words=2 -> rd_adx 0x7FFFFF8 then 0x0000000.
- Second word returned with return_adx=0x200 instead of 0x108 -> adx_error rises and stays set; data still emitted; next start clears it.
- num_words=0 -> no read_req; done pulses 2 cycles after start. Separately, reset asserted after 3 samples -> all outputs at reset values next cycle; no done pulse.
